// File: rtl/adc_serial_responder_if.sv
// rtl/adc_serial_responder_if.sv - reader-side bus of the serial ADC emulator
interface adc_serial_responder_if #(
  parameter int DATA_W = 12
);
  logic              CS;
  logic              Clock_Muestreo;
  logic [DATA_W-1:0] sample_in;
  logic              sample_load;
  logic              data_ADC;
  logic              busy;
  logic              frame_done;
  logic              frame_abort;

  // Reader / sample source side
  modport master (
    output CS, Clock_Muestreo, sample_in, sample_load,
    input  data_ADC, busy, frame_done, frame_abort
  );

  // Emulated ADC side
  modport slave (
    input  CS, Clock_Muestreo, sample_in, sample_load,
    output data_ADC, busy, frame_done, frame_abort
  );
endinterface

// File: rtl/adc_serial_responder.sv
// rtl/adc_serial_responder.sv - serial ADC emulator answering CS / Clock_Muestreo
module adc_serial_responder #(
  parameter int DATA_W      = 12,
  parameter int LEAD_ZEROS  = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   Clock_Nexys,
  input  logic                   Reset,
  adc_serial_responder_if.slave  bus
);
  localparam int FRAME = LEAD_ZEROS + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam int FL_W  = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);
  localparam logic [FL_W-1:0]  FLUSH_N   = FL_W'(SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, SHIFT, TRAIL} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sclk_sync;
  logic                   cs_d;
  logic                   sclk_d;
  logic [FL_W-1:0]        flush_cnt;
  logic                   armed;
  logic [DATA_W-1:0]      hold;
  logic [FRAME-1:0]       shifter;
  logic [CNT_W-1:0]       bit_cnt;

  logic                   cs_s;
  logic                   sclk_s;
  logic                   cs_fall;
  logic                   cs_rise;
  logic                   sclk_fall;
  logic [DATA_W-1:0]      load_val;
  logic [FRAME-1:0]       frame_word;

  // Edge detection on the last two synchronized samples; a frame may only
  // start once CS has been seen high with a fully flushed synchronizer, so a
  // CS held low through reset never looks like a fresh falling edge.
  always_comb begin
    cs_s       = cs_sync[SYNC_STAGES-1];
    sclk_s     = sclk_sync[SYNC_STAGES-1];
    cs_fall    = armed & cs_d & ~cs_s;
    cs_rise    = ~cs_d & cs_s;
    sclk_fall  = sclk_d & ~sclk_s;
    load_val   = bus.sample_load ? bus.sample_in : hold;
    frame_word = {{LEAD_ZEROS{1'b0}}, load_val};
  end

  // Synchronizers for the asynchronous reader signals, idle-high after reset
  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset) begin
      cs_sync   <= '1;
      sclk_sync <= '1;
      cs_d      <= 1'b1;
      sclk_d    <= 1'b1;
    end else begin
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.CS};
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.Clock_Muestreo};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // Arm frame start once the synchronizer holds real samples and CS is high
  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset) begin
      flush_cnt <= '0;
      armed     <= 1'b0;
    end else if (flush_cnt != FLUSH_N) begin
      flush_cnt <= flush_cnt + FL_W'(1);
    end else if (cs_s) begin
      armed <= 1'b1;
    end
  end

  // Sample hold register, written in any state
  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset) begin
      hold <= '0;
    end else if (bus.sample_load) begin
      hold <= bus.sample_in;
    end
  end

  // Frame FSM: registered serial data, busy and end-of-frame pulses
  always_ff @(posedge Clock_Nexys or posedge Reset) begin
    if (Reset) begin
      state           <= IDLE;
      shifter         <= '0;
      bit_cnt         <= '0;
      bus.data_ADC    <= 1'b0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;
    end else begin
      bus.frame_done  <= 1'b0;
      bus.frame_abort <= 1'b0;
      case (state)
        IDLE: begin
          bus.data_ADC <= 1'b0;
          if (cs_fall) begin
            shifter      <= frame_word;
            bus.data_ADC <= frame_word[FRAME-1];
            bit_cnt      <= CNT_W'(1);
            bus.busy     <= 1'b1;
            state        <= SHIFT;
          end
        end
        SHIFT: begin
          if (cs_rise) begin
            bus.frame_abort <= 1'b1;
            bus.data_ADC    <= 1'b0;
            bus.busy        <= 1'b0;
            state           <= IDLE;
          end else if (sclk_fall) begin
            if (bit_cnt == FRAME_CNT) begin
              bus.data_ADC <= 1'b0;
              bus.busy     <= 1'b0;
              state        <= TRAIL;
            end else begin
              shifter      <= {shifter[FRAME-2:0], 1'b0};
              bus.data_ADC <= shifter[FRAME-2];
              bit_cnt      <= bit_cnt + CNT_W'(1);
            end
          end
        end
        TRAIL: begin
          bus.data_ADC <= 1'b0;
          if (cs_rise) begin
            bus.frame_done <= 1'b1;
            state          <= IDLE;
          end
        end
        default: begin
          bus.data_ADC <= 1'b0;
          bus.busy     <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end
endmodule
